// File: rtl/acc_chain_if.sv
// acc_chain_if: operand input stream and result output stream of the accumulation sequencer
interface acc_chain_if #(parameter int N = 8);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/acc_chain_sequencer.sv
// acc_chain_sequencer: sequences one add/multiply accumulation job over len operand beats
module acc_chain_sequencer #(
  parameter int N = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             mode,
  acc_chain_if.slave       bus,
  output logic             busy,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t           state, state_nx;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] count;
  logic             mode_q;
  logic             fire;
  logic [N:0]       sum;
  logic [2*N-1:0]   prod;
  assign fire = (state == ACCUM) && bus.in_valid;
  assign sum = (N+1)'(acc) + (N+1)'(bus.in_data);
  assign prod = (2*N)'(acc) * (2*N)'(bus.in_data);
  assign bus.in_ready = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data = acc;
  assign busy = (state != IDLE);
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next state: a zero-length job goes straight to HOLD to present the identity value
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ((len != '0) ? ACCUM : HOLD) : IDLE;
      ACCUM:   state_nx = (fire && count == CNT_W'(1)) ? HOLD : ACCUM;
      HOLD:    state_nx = bus.out_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  // accumulator, beat counter and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= N'(1);
      count    <= '0;
      overflow <= 1'b0;
      mode_q   <= 1'b0;
    end else if (state == IDLE && start) begin
      mode_q   <= mode;
      acc      <= N'(mode);
      overflow <= 1'b0;
      count    <= len;
    end else if (fire) begin
      acc      <= mode_q ? prod[N-1:0] : sum[N-1:0];
      overflow <= overflow | (mode_q ? |prod[2*N-1:N] : sum[N]);
      count    <= count - CNT_W'(1);
    end
  end
endmodule
